// File: rtl/adder_share_arbiter.sv
// Purpose: round-robin share of one external combinational adder among NUM_REQ requesters.
// Latency: rsp_valid appears ADD_LATENCY+1 cycles after the accept cycle; one op per ADD_LATENCY+2 cycles at best.
// Backpressure: rsp_ready low holds the response and blocks all new accepts (req_ready stays zero).
module adder_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 32,
  parameter int ADD_LATENCY = 1,
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  input  logic                     add_overflow,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     rsp_overflow,
  output logic                     busy
);

  localparam int LCW = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
  localparam logic [LCW-1:0] LAT_LAST = LCW'(ADD_LATENCY - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   winner;
  logic             any_vld;
  logic             accept;
  logic             exec_done;
  logic             rsp_done;
  logic [LCW-1:0]   lat_cnt;
  int               idx;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    winner  = '0;
    any_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any_vld && req_valid[idx]) begin
        any_vld = 1'b1;
        winner  = IDW'(idx);
      end
    end
  end

  // Grant is one-hot on the winner, and only while idle.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_vld) req_ready[winner] = 1'b1;
  end

  assign accept    = (state == IDLE) && any_vld;
  assign exec_done = (state == EXEC) && (lat_cnt == LAT_LAST);
  assign rsp_done  = rsp_valid && rsp_ready;
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> EXEC -> RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = EXEC;
      EXEC:    if (exec_done) state_nxt = RESP;
      RESP:    if (rsp_done)  state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Operand latch on accept, latency count during EXEC, result capture and response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      lat_cnt      <= '0;
      add_a        <= '0;
      add_b        <= '0;
      add_cin      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      if (accept) begin
        add_a   <= req_a[int'(winner)*WIDTH +: WIDTH];
        add_b   <= req_b[int'(winner)*WIDTH +: WIDTH];
        add_cin <= req_cin[winner];
        rsp_id  <= winner;
        rr_ptr  <= (winner == LAST_ID) ? '0 : winner + 1'b1;
        lat_cnt <= '0;
      end else if (state == EXEC) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
      if (exec_done) begin
        rsp_sum      <= add_sum;
        rsp_cout     <= add_cout;
        rsp_overflow <= add_overflow;
        rsp_valid    <= 1'b1;
      end else if (rsp_done) begin
        rsp_valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Purpose: directed checks of the shared-adder arbiter at ADD_LATENCY 1 and 3.
// Latency: external adder modelled as pure combinational logic.
// Backpressure: rsp_ready is driven low for a hold window in one scenario.
module tb_adder_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc_now = 0;
  // Free-running cycle counter used to measure grant spacing.
  always @(posedge clk) cyc_now <= cyc_now + 1;

  // DUT with ADD_LATENCY = 1
  logic [N-1:0]   req_valid, req_ready, req_cin;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   add_a, add_b, add_sum, rsp_sum;
  logic           add_cin, add_cout, add_ovf;
  logic           rsp_valid, rsp_ready, rsp_cout, rsp_ovf, busy;
  logic [1:0]     rsp_id;
  logic [W:0]     full;

  assign full    = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_sum = full[W-1:0];
  assign add_cout = full[W];
  assign add_ovf = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);

  adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADD_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .add_overflow(add_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_overflow(rsp_ovf),
    .busy(busy)
  );

  // DUT with ADD_LATENCY = 3
  logic [N-1:0]   req_valid_3, req_ready_3, req_cin_3;
  logic [N*W-1:0] req_a_3, req_b_3;
  logic [W-1:0]   add_a_3, add_b_3, add_sum_3, rsp_sum_3;
  logic           add_cin_3, add_cout_3, add_ovf_3;
  logic           rsp_valid_3, rsp_ready_3, rsp_cout_3, rsp_ovf_3, busy_3;
  logic [1:0]     rsp_id_3;
  logic [W:0]     full_3;

  assign full_3     = {1'b0, add_a_3} + {1'b0, add_b_3} + {{W{1'b0}}, add_cin_3};
  assign add_sum_3  = full_3[W-1:0];
  assign add_cout_3 = full_3[W];
  assign add_ovf_3  = (add_a_3[W-1] == add_b_3[W-1]) && (add_sum_3[W-1] != add_a_3[W-1]);

  adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_3), .req_ready(req_ready_3),
    .req_a(req_a_3), .req_b(req_b_3), .req_cin(req_cin_3),
    .add_a(add_a_3), .add_b(add_b_3), .add_cin(add_cin_3),
    .add_sum(add_sum_3), .add_cout(add_cout_3), .add_overflow(add_ovf_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_id(rsp_id_3),
    .rsp_sum(rsp_sum_3), .rsp_cout(rsp_cout_3), .rsp_overflow(rsp_ovf_3),
    .busy(busy_3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Raise one request, wait for its grant, then count cycles (accept cycle = 0) until rsp_valid.
  task automatic run_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, output int lat);
    int n = 0;
    req_valid = '0;
    req_valid[i] = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i] = cin;
    #1;
    while (!req_ready[i] && n < 50) begin
      @(posedge clk); #2; n++;
    end
    check("accept", {63'd0, req_ready[i]}, 64'd1);
    @(posedge clk); #1;
    req_valid = '0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  initial begin
    int lat, n, last, stale;
    logic a_stable;
    logic [N-1:0] exp_rdy;

    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b1;
    req_valid_3 = '0; req_a_3 = '0; req_b_3 = '0; req_cin_3 = '0; rsp_ready_3 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp", {rsp_id, rsp_sum, rsp_cout, rsp_ovf}, 64'd0);
    check("rst_add", {add_a, add_b[30:0], add_cin}, 64'd0);
    check("rst_rdy", {60'd0, req_ready}, 64'd0);
    check("rst_busy3", {63'd0, busy_3}, 64'd0);

    // single op on requester 0
    run_op(0, 32'd10, 32'd15, 1'b0, lat);
    check("t1_lat", lat, 64'd2);
    check("t1_sum", {32'd0, rsp_sum}, 64'd25);
    check("t1_flags", {rsp_id, rsp_cout, rsp_ovf}, 64'd0);
    @(posedge clk); #1;
    check("t1_done", {62'd0, rsp_valid, busy}, 64'd0);

    // signed overflow corner cases
    run_op(2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, lat);
    check("t2a_sum", {32'd0, rsp_sum}, 64'hFFFF_FFFE);
    check("t2a_flags", {rsp_id, rsp_cout, rsp_ovf}, {60'd0, 2'd2, 1'b0, 1'b1});
    @(posedge clk); #1;
    run_op(1, 32'h8000_0000, 32'h8000_0000, 1'b0, lat);
    check("t2b_sum", {32'd0, rsp_sum}, 64'd0);
    check("t2b_flags", {rsp_id, rsp_cout, rsp_ovf}, {60'd0, 2'd1, 1'b1, 1'b1});
    @(posedge clk); #1;

    // requester 3 alone: rr_ptr must wrap back to 0 afterwards
    run_op(3, 32'd1, 32'd2, 1'b1, lat);
    check("wrap_sum", {rsp_id, rsp_sum}, {30'd0, 2'd3, 32'd4});
    @(posedge clk); #1;

    // all four requesting continuously: grants 0,1,2,3,0,1 every 3 cycles
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'(i * 100 + 1);
      req_b[i*W +: W] = 32'(i);
      req_cin[i] = 1'b0;
    end
    req_valid = 4'hF;
    #1;
    last = 0;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      while (req_ready == '0 && n < 20) begin
        @(posedge clk); #2; n++;
      end
      exp_rdy = '0;
      exp_rdy[g % 4] = 1'b1;
      check("t3_grant", {60'd0, req_ready}, {60'd0, exp_rdy});
      if (g > 0) check("t3_gap", cyc_now - last, 64'd3);
      last = cyc_now;
      n = 0;
      do begin
        @(posedge clk); #2; n++;
      end while (!rsp_valid && n < 20);
      check("t3_id", {62'd0, rsp_id}, 64'(g % 4));
      check("t3_sum", {32'd0, rsp_sum}, 64'((g % 4) * 101 + 1));
    end
    req_valid = '0;
    @(posedge clk); #1;

    // backpressure: response held 10 cycles, no grants meanwhile
    rsp_ready = 1'b0;
    run_op(2, 32'd5, 32'd6, 1'b1, lat);
    check("t4_lat", lat, 64'd2);
    req_valid[0] = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("t4_hold", {rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf},
            {27'd0, 1'b1, 2'd2, 32'd12, 2'b00});
      #1 check("t4_rdy", {60'd0, req_ready}, 64'd0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_release", {62'd0, rsp_valid, busy}, 64'd0);

    // reset while in EXEC aborts the operation and clears rr_ptr
    req_valid = 4'b0100;
    req_a[2*W +: W] = 32'hFFFF_FFF6;
    req_b[2*W +: W] = 32'hFFFF_FFF6;
    req_cin[2] = 1'b0;
    #1 check("t5_grant", {60'd0, req_ready}, 64'h4);
    @(posedge clk); #1;
    req_valid = '0;
    check("t5_exec", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_abort", {62'd0, busy, rsp_valid}, 64'd0);
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid) stale++;
    end
    check("t5_stale", stale, 64'd0);
    req_valid = 4'hF;
    #1 check("t5_ptr", {60'd0, req_ready}, 64'h1);
    req_valid = '0;
    @(posedge clk); #1;

    // ADD_LATENCY = 3: carry ripple through all ones
    req_valid_3 = 4'b0001;
    req_a_3[0 +: W] = 32'hFFFF_FFFF;
    req_b_3[0 +: W] = 32'd0;
    req_cin_3[0] = 1'b1;
    #1 check("t6_grant", {60'd0, req_ready_3}, 64'h1);
    @(posedge clk); #1;
    req_valid_3 = '0;
    lat = 1;
    a_stable = 1'b1;
    while (!rsp_valid_3 && lat < 50) begin
      if (add_a_3 !== 32'hFFFF_FFFF) a_stable = 1'b0;
      @(posedge clk); #1; lat++;
    end
    check("t6_lat", lat, 64'd4);
    check("t6_a_stable", {63'd0, a_stable}, 64'd1);
    check("t6_sum", {32'd0, rsp_sum_3}, 64'd0);
    check("t6_flags", {rsp_id_3, rsp_cout_3, rsp_ovf_3}, {60'd0, 2'd0, 1'b1, 1'b0});
    @(posedge clk); #1;
    check("t6_done", {63'd0, rsp_valid_3}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
